perf_commit_monitor: RTL and testbench

- Synthesizable commit-side event monitor. Sits directly downstream of the pipeline's writeback/memory commit signals and cache controllers.
- Counts cycles, retired instructions, loads, stores and I/D cache requests and hits.
- Freezes all counts when halt commits, and exposes them through a registered read port for the test harness and debug logic.
- Event qualification matches the team's simulation trace rules, so hardware counts equal logged counts.

---
 rtl/perf_commit_monitor.sv | 109 ++++++++++
 tb/tb_perf_commit_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/perf_commit_monitor.sv
// Commit-side event counters (cycles/inst/load/store/I$/D$), frozen on halt; optional PERF_CNT_SATURATE_EN saturates instead of wrapping.
// Read port is registered with 1-cycle latency; pure monitor, no backpressure on the pipeline.
module perf_commit_monitor #(
   parameter int CNT_W           = 32,
   parameter bit CLR_ON_HALT_ACK = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reg_write,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             halt,
   input  logic             icache_req,
   input  logic             icache_hit,
   input  logic             dcache_req,
   input  logic             dcache_hit,
   input  logic             clear,
   input  logic             halt_ack,
   input  logic [2:0]       rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic             halted,
   output logic             proto_err
);

   typedef enum logic {RUN, FROZEN} state_t;

   state_t                  state, stateNext;
   logic [7:0][CNT_W-1:0]   cnt;
   logic [7:0]              evt;
   logic                    clrAll;
   logic                    countEn;
   logic                    protoHit;

   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_CNT_SATURATE_EN
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
`else
      return v + CNT_W'(1);
`endif
   endfunction

   // Stores are keyed on mem_write alone; mem_read is don't-care for them.
   always_comb begin
      evt    = '0;
      evt[0] = 1'b1;
      evt[1] = halt | reg_write | mem_write;
      evt[2] = mem_read & ~mem_write;
      evt[3] = mem_write;
      evt[4] = icache_req;
      evt[5] = icache_hit;
      evt[6] = dcache_req;
      evt[7] = dcache_hit;
   end

   assign protoHit = (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);

   always_comb begin
      stateNext = state;
      clrAll    = clear;
      countEn   = 1'b0;
      case (state)
         RUN: begin
            countEn = ~clear;
            if (halt) stateNext = FROZEN;
         end
         FROZEN: begin
            if (halt_ack) begin
               stateNext = RUN;
               if (CLR_ON_HALT_ACK) clrAll = 1'b1;
            end
         end
         default: stateNext = RUN;
      endcase
      // clear overrides everything, including a same-cycle halt
      if (clear) stateNext = RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= stateNext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clrAll) begin
         cnt <= '0;
      end else if (countEn) begin
         for (int i = 0; i < 8; i++) begin
            if (evt[i]) cnt[i] <= bump(cnt[i]);
         end
      end
   end

   // Samples the pre-update counter value, giving a 1-cycle read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= cnt[rd_sel];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           proto_err <= 1'b0;
      else if (clrAll)   proto_err <= 1'b0;
      else if (protoHit) proto_err <= 1'b1;
   end

   assign halted = (state == FROZEN);

endmodule

// File: tb/tb_perf_commit_monitor.sv
// Directed bench for perf_commit_monitor: an 8-bit instance and a 16-bit instance with CLR_ON_HALT_ACK=1 share the stimulus.
module tb_perf_commit_monitor;

   logic        clk;
   logic        rst;
   logic        regWrite, memRead, memWrite, halt;
   logic        icacheReq, icacheHit, dcacheReq, dcacheHit;
   logic        clear, haltAck;
   logic [2:0]  rdSel;
   logic [7:0]  rdDataA;
   logic [15:0] rdDataC;
   logic        haltedA, haltedC, protoErrA, protoErrC;

   int checks = 0;
   int errors = 0;

   perf_commit_monitor #(.CNT_W(8), .CLR_ON_HALT_ACK(1'b0)) dutA (
      .clk(clk), .rst(rst), .reg_write(regWrite), .mem_read(memRead), .mem_write(memWrite),
      .halt(halt), .icache_req(icacheReq), .icache_hit(icacheHit), .dcache_req(dcacheReq),
      .dcache_hit(dcacheHit), .clear(clear), .halt_ack(haltAck), .rd_sel(rdSel),
      .rd_data(rdDataA), .halted(haltedA), .proto_err(protoErrA)
   );

   perf_commit_monitor #(.CNT_W(16), .CLR_ON_HALT_ACK(1'b1)) dutC (
      .clk(clk), .rst(rst), .reg_write(regWrite), .mem_read(memRead), .mem_write(memWrite),
      .halt(halt), .icache_req(icacheReq), .icache_hit(icacheHit), .dcache_req(dcacheReq),
      .dcache_hit(dcacheHit), .clear(clear), .halt_ack(haltAck), .rd_sel(rdSel),
      .rd_data(rdDataC), .halted(haltedC), .proto_err(protoErrC)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      regWrite = 0; memRead = 0; memWrite = 0; halt = 0;
      icacheReq = 0; icacheHit = 0; dcacheReq = 0; dcacheHit = 0;
      clear = 0; haltAck = 0;
   endtask

   task automatic doClear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   // Presents rd_sel for one edge and returns with rd_data holding the pre-edge counter.
   task automatic readSel(input logic [2:0] sel);
      rdSel = sel;
      step();
   endtask

   localparam logic [31:0] WRAP_EXP =
`ifdef PERF_CNT_SATURATE_EN
      32'd255;
`else
      32'd44;
`endif

   initial begin
      idle();
      rdSel = 3'd0;
      rst   = 1'b1;
      step();
      step();
      checkVal("rst_rd_data", 32'(rdDataA), 0);
      checkVal("rst_halted", 32'(haltedA), 0);
      checkVal("rst_proto_err", 32'(protoErrA), 0);
      rst = 1'b0;

      // 10 cycles: reg_write on 2,4,6, halt on 9
      for (int i = 1; i <= 10; i++) begin
         regWrite = (i == 2 || i == 4 || i == 6);
         halt     = (i == 9);
         step();
      end
      idle();
      checkVal("halt_halted", 32'(haltedA), 1);
      readSel(3'd0); checkVal("halt_cycles", 32'(rdDataA), 9);
      readSel(3'd1); checkVal("halt_inst", 32'(rdDataA), 4);
      repeat (5) step();
      readSel(3'd0); checkVal("frozen_cycles", 32'(rdDataA), 9);
      checkVal("frozen_cycles_c", 32'(rdDataC), 9);

      // halt_ack: A unfreezes with counts kept, C also zeroes
      haltAck = 1'b1;
      step();
      haltAck = 1'b0;
      checkVal("ack_halted", 32'(haltedA), 0);
      checkVal("ack_halted_c", 32'(haltedC), 0);
      readSel(3'd0);
      checkVal("ack_cycles", 32'(rdDataA), 9);
      checkVal("ack_cycles_c", 32'(rdDataC), 0);
      readSel(3'd0);
      checkVal("ack_resume", 32'(rdDataA), 10);
      checkVal("ack_resume_c", 32'(rdDataC), 1);

      // loads vs stores
      doClear();
      memRead = 1'b1;
      repeat (3) step();
      memWrite = 1'b1;
      repeat (2) step();
      idle();
      readSel(3'd2); checkVal("load", 32'(rdDataA), 3);
      readSel(3'd3); checkVal("store", 32'(rdDataA), 2);
      readSel(3'd1); checkVal("inst_store", 32'(rdDataA), 2);

      // cache events and protocol error
      doClear();
      icacheReq = 1'b1;
      for (int i = 0; i < 6; i++) begin
         icacheHit = (i < 4);
         step();
      end
      idle();
      checkVal("no_proto_err", 32'(protoErrA), 0);
      dcacheHit = 1'b1;
      step();
      idle();
      checkVal("proto_err", 32'(protoErrA), 1);
      readSel(3'd4); checkVal("ireq", 32'(rdDataA), 6);
      readSel(3'd5); checkVal("ihit", 32'(rdDataA), 4);
      readSel(3'd7); checkVal("dhit", 32'(rdDataA), 1);
      readSel(3'd6); checkVal("dreq", 32'(rdDataA), 0);
      doClear();
      checkVal("clr_proto_err", 32'(protoErrA), 0);
      readSel(3'd4); checkVal("clr_ireq", 32'(rdDataA), 0);
      readSel(3'd7); checkVal("clr_dhit", 32'(rdDataA), 0);

      // clear beats halt in the same cycle
      clear = 1'b1;
      halt  = 1'b1;
      step();
      idle();
      checkVal("clrhalt_halted", 32'(haltedA), 0);
      readSel(3'd0); checkVal("clrhalt_cycles", 32'(rdDataA), 0);
      readSel(3'd0); checkVal("clrhalt_resume", 32'(rdDataA), 1);
      readSel(3'd1); checkVal("clrhalt_inst", 32'(rdDataA), 0);

      // halt and halt_ack together while frozen: ack wins, cycle not counted
      doClear();
      halt = 1'b1;
      step();
      checkVal("freeze_halted", 32'(haltedA), 1);
      haltAck = 1'b1;
      step();
      idle();
      checkVal("both_halted", 32'(haltedA), 0);
      readSel(3'd0);
      checkVal("both_cycles", 32'(rdDataA), 1);
      checkVal("both_cycles_c", 32'(rdDataC), 0);
      readSel(3'd1); checkVal("both_inst", 32'(rdDataA), 1);

      // 300 run cycles on the 8-bit counter
      doClear();
      repeat (300) step();
      readSel(3'd0);
      checkVal("cnt8_overflow", 32'(rdDataA), WRAP_EXP);
      checkVal("cnt16_300", 32'(rdDataC), 300);

      // asynchronous reset between edges
      icacheHit = 1'b1;
      step();
      icacheHit = 1'b0;
      halt      = 1'b1;
      step();
      idle();
      checkVal("pre_rst_halted", 32'(haltedA), 1);
      checkVal("pre_rst_proto", 32'(protoErrA), 1);
      #2 rst = 1'b1;
      #1;
      checkVal("arst_rd_data", 32'(rdDataA), 0);
      checkVal("arst_halted", 32'(haltedA), 0);
      checkVal("arst_proto", 32'(protoErrA), 0);
      #2 rst = 1'b0;
      readSel(3'd0); checkVal("post_rst_cycles0", 32'(rdDataA), 0);
      readSel(3'd0); checkVal("post_rst_cycles1", 32'(rdDataA), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
